// File: rtl/ex_hazard_ctrl_pkg.sv
// Shared definitions for the EX-stage hazard controller: forward select
// encodings, FSM state type and default register index width.
package ex_hazard_ctrl_pkg;

  localparam int REG_AW_DEFAULT = 5;

  // Stall countdown width; holds LOAD_LAT-1 for LOAD_LAT up to 7.
  localparam int CNT_W = 3;

  // EX operand mux selects.
  localparam logic [1:0] FWD_RF  = 2'b00;  // register file read value
  localparam logic [1:0] FWD_WB  = 2'b01;  // value being written back
  localparam logic [1:0] FWD_MEM = 2'b10;  // alu_result held in MEM

  typedef enum logic {
    RUN   = 1'b0,
    STALL = 1'b1
  } state_t;

endpackage

// File: rtl/ex_fwd_sel.sv
// Combinational forward-source priority for one ID source operand.
// The instruction now in EX will sit in MEM when the ID instruction
// reaches EX, so it is the newer producer and wins over MEM. x0 never
// forwards.
module ex_fwd_sel
  import ex_hazard_ctrl_pkg::*;
#(
  parameter int REG_AW = REG_AW_DEFAULT
) (
  input  logic              src_en,
  input  logic [REG_AW-1:0] src,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_reg_write,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic              mem_reg_write,
  output logic [1:0]        sel
);

  // Priority compare: EX producer, then MEM producer, else register file.
  always_comb begin
    sel = FWD_RF;
    if (src_en && (src != '0)) begin
      if (ex_reg_write && (ex_rd == src)) begin
        sel = FWD_MEM;
      end else if (mem_reg_write && (mem_rd == src)) begin
        sel = FWD_WB;
      end
    end
  end

endmodule

// File: rtl/ex_hazard_ctrl.sv
// EX-stage hazard controller: registered operand forwarding selects,
// load-use stall sequencing and branch flush.
//
// Control semantics: stall_if/stall_id/bubble_ex/flush_id are level
// signals that take effect at the next clock edge; there is no
// handshake. While stall_if is high the front end must hold PC, IF/ID
// and ID unchanged, and bubble_ex loads a NOP into ID/EX at that edge.
// A taken branch overrides any stall: the front end is released and
// IF/ID is squashed.
//
// Optional build macro: HAZARD_STATS_EN adds saturating counters for
// stall cycles and flushes.
// dbg_state/dbg_cnt expose the FSM for observation.
module ex_hazard_ctrl
  import ex_hazard_ctrl_pkg::*;
#(
  parameter int LOAD_LAT = 1,
  parameter int REG_AW   = REG_AW_DEFAULT
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use_rs2,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_reg_write,
  input  logic              ex_mem_read,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic              mem_reg_write,
  input  logic              branch_taken,
  output logic              stall_if,
  output logic              stall_id,
  output logic              bubble_ex,
  output logic              flush_id,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic              dbg_state,
  output logic [CNT_W-1:0]  dbg_cnt
`ifdef HAZARD_STATS_EN
  ,
  output logic [31:0]       stat_stall_cycles,
  output logic [31:0]       stat_flushes
`endif
);

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             hit_rs1, hit_rs2, load_use;
  logic [1:0]       sel_a, sel_b;

  // Load-use detect against the load currently in EX.
  assign hit_rs1  = (ex_rd != '0) && (ex_rd == id_rs1);
  assign hit_rs2  = (ex_rd != '0) && (ex_rd == id_rs2) && id_use_rs2;
  assign load_use = id_valid && ex_mem_read && ex_reg_write && (hit_rs1 || hit_rs2);

  ex_fwd_sel #(.REG_AW(REG_AW)) u_fwd_a (
    .src_en        (1'b1),
    .src           (id_rs1),
    .ex_rd         (ex_rd),
    .ex_reg_write  (ex_reg_write),
    .mem_rd        (mem_rd),
    .mem_reg_write (mem_reg_write),
    .sel           (sel_a)
  );

  ex_fwd_sel #(.REG_AW(REG_AW)) u_fwd_b (
    .src_en        (id_use_rs2),
    .src           (id_rs2),
    .ex_rd         (ex_rd),
    .ex_reg_write  (ex_reg_write),
    .mem_rd        (mem_rd),
    .mem_reg_write (mem_reg_write),
    .sel           (sel_b)
  );

  // FSM state and stall countdown register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // Next state and control outputs; all controls forced low in reset.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    stall_if  = 1'b0;
    stall_id  = 1'b0;
    bubble_ex = 1'b0;
    flush_id  = 1'b0;
    if (reset_n) begin
      if (branch_taken) begin
        flush_id  = 1'b1;
        bubble_ex = 1'b1;
        state_n   = RUN;
        cnt_n     = '0;
      end else begin
        case (state)
          RUN: begin
            if (load_use) begin
              stall_if  = 1'b1;
              stall_id  = 1'b1;
              bubble_ex = 1'b1;
              if (LOAD_LAT > 1) begin
                state_n = STALL;
                cnt_n   = CNT_W'(LOAD_LAT - 1);
              end
            end
          end
          STALL: begin
            stall_if  = 1'b1;
            stall_id  = 1'b1;
            bubble_ex = 1'b1;
            if (cnt == CNT_W'(1)) begin
              state_n = RUN;
              cnt_n   = '0;
            end else begin
              cnt_n = cnt - CNT_W'(1);
            end
          end
          default: begin
            state_n = RUN;
            cnt_n   = '0;
          end
        endcase
      end
    end
  end

  // Forward selects travel with the instruction into EX; bubbles and
  // empty ID slots carry register-file selects.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      fwd_a <= FWD_RF;
      fwd_b <= FWD_RF;
    end else if (bubble_ex || !id_valid) begin
      fwd_a <= FWD_RF;
      fwd_b <= FWD_RF;
    end else begin
      fwd_a <= sel_a;
      fwd_b <= sel_b;
    end
  end

  assign dbg_state = state;
  assign dbg_cnt   = cnt;

`ifdef HAZARD_STATS_EN
  // Saturating event counters.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      stat_stall_cycles <= '0;
      stat_flushes      <= '0;
    end else begin
      if (stall_if && (stat_stall_cycles != 32'hFFFF_FFFF))
        stat_stall_cycles <= stat_stall_cycles + 32'd1;
      if (flush_id && (stat_flushes != 32'hFFFF_FFFF))
        stat_flushes <= stat_flushes + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ex_hazard_ctrl.sv
// Directed bench for ex_hazard_ctrl: single-cycle vector table plus
// hand-written load-use, branch-during-stall and reset-mid-stall
// sequences. Two instances share inputs: LOAD_LAT=3 and LOAD_LAT=1.
module tb_ex_hazard_ctrl;
  import ex_hazard_ctrl_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_n;
  logic       id_valid, id_use_rs2, ex_reg_write, ex_mem_read, mem_reg_write, branch_taken;
  logic [4:0] id_rs1, id_rs2, ex_rd, mem_rd;

  logic       stall_if, stall_id, bubble_ex, flush_id, dbg_state;
  logic [1:0] fwd_a, fwd_b;
  logic [2:0] dbg_cnt;
  logic       stall_if_1, stall_id_1, bubble_ex_1, flush_id_1, dbg_state_1;
  logic [1:0] fwd_a_1, fwd_b_1;
  logic [2:0] dbg_cnt_1;
`ifdef HAZARD_STATS_EN
  logic [31:0] stat_stall_cycles, stat_flushes, stat_stall_cycles_1, stat_flushes_1;
`endif

  ex_hazard_ctrl #(.LOAD_LAT(3), .REG_AW(5)) u_dut (
    .clk(clk), .reset_n(reset_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs2(id_use_rs2), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .mem_rd(mem_rd), .mem_reg_write(mem_reg_write),
    .branch_taken(branch_taken), .stall_if(stall_if), .stall_id(stall_id),
    .bubble_ex(bubble_ex), .flush_id(flush_id), .fwd_a(fwd_a), .fwd_b(fwd_b),
    .dbg_state(dbg_state), .dbg_cnt(dbg_cnt)
`ifdef HAZARD_STATS_EN
    , .stat_stall_cycles(stat_stall_cycles), .stat_flushes(stat_flushes)
`endif
  );

  ex_hazard_ctrl #(.LOAD_LAT(1), .REG_AW(5)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs2(id_use_rs2), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .mem_rd(mem_rd), .mem_reg_write(mem_reg_write),
    .branch_taken(branch_taken), .stall_if(stall_if_1), .stall_id(stall_id_1),
    .bubble_ex(bubble_ex_1), .flush_id(flush_id_1), .fwd_a(fwd_a_1), .fwd_b(fwd_b_1),
    .dbg_state(dbg_state_1), .dbg_cnt(dbg_cnt_1)
`ifdef HAZARD_STATS_EN
    , .stat_stall_cycles(stat_stall_cycles_1), .stat_flushes(stat_flushes_1)
`endif
  );

  // ---------------- scoreboard ----------------
  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- driver ----------------
  typedef struct {
    logic       valid;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       use_rs2;
    logic [4:0] ex_rd;
    logic       ex_w;
    logic       ex_load;
    logic [4:0] mem_rd;
    logic       mem_w;
    logic       br;
    logic       e_stall;
    logic       e_bubble;
    logic       e_flush;
    logic [1:0] e_fa;
    logic [1:0] e_fb;
  } vec_t;

  vec_t vec[12];

  task automatic drive(input logic v, input logic [4:0] r1, input logic [4:0] r2,
                       input logic u2, input logic [4:0] erd, input logic ew,
                       input logic el, input logic [4:0] mrd, input logic mw,
                       input logic br);
    id_valid      = v;
    id_rs1        = r1;
    id_rs2        = r2;
    id_use_rs2    = u2;
    ex_rd         = erd;
    ex_reg_write  = ew;
    ex_mem_read   = el;
    mem_rd        = mrd;
    mem_reg_write = mw;
    branch_taken  = br;
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_stats(input string tag, input logic [31:0] e_stall, input logic [31:0] e_flush);
`ifdef HAZARD_STATS_EN
    check({tag, " stat_stall_cycles"}, stat_stall_cycles, e_stall);
    check({tag, " stat_flushes"}, stat_flushes, e_flush);
`else
    if (tag.len() == 0 && e_stall == e_flush) begin
    end
`endif
  endtask

  initial begin
    //         v  rs1   rs2   u  exrd  ew el  memrd mw br | st bu fl fa     fb
    vec[0]  = '{1, 5'd5, 5'd0, 1, 5'd5, 1, 0, 5'd0, 0, 0,   0, 0, 0, 2'b10, 2'b00};
    vec[1]  = '{1, 5'd3, 5'd7, 1, 5'd7, 1, 0, 5'd7, 1, 0,   0, 0, 0, 2'b00, 2'b10};
    vec[2]  = '{1, 5'd3, 5'd7, 0, 5'd7, 1, 0, 5'd7, 1, 0,   0, 0, 0, 2'b00, 2'b00};
    vec[3]  = '{1, 5'd9, 5'd0, 0, 5'd9, 0, 0, 5'd9, 1, 0,   0, 0, 0, 2'b01, 2'b00};
    vec[4]  = '{1, 5'd2, 5'd6, 1, 5'd2, 1, 0, 5'd6, 1, 0,   0, 0, 0, 2'b10, 2'b01};
    vec[5]  = '{0, 5'd2, 5'd6, 1, 5'd2, 1, 0, 5'd6, 1, 0,   0, 0, 0, 2'b00, 2'b00};
    vec[6]  = '{1, 5'd0, 5'd0, 1, 5'd0, 1, 1, 5'd0, 1, 0,   0, 0, 0, 2'b00, 2'b00};
    vec[7]  = '{1, 5'd5, 5'd0, 1, 5'd5, 1, 0, 5'd0, 0, 1,   0, 1, 1, 2'b00, 2'b00};
    vec[8]  = '{1, 5'd4, 5'd0, 0, 5'd4, 1, 1, 5'd0, 0, 1,   0, 1, 1, 2'b00, 2'b00};
    vec[9]  = '{1, 5'd5, 5'd4, 0, 5'd4, 1, 1, 5'd0, 0, 0,   0, 0, 0, 2'b00, 2'b00};
    vec[10] = '{1, 5'd8, 5'd0, 0, 5'd0, 0, 0, 5'd8, 0, 0,   0, 0, 0, 2'b00, 2'b00};
    vec[11] = '{1, 5'd8, 5'd8, 1, 5'd8, 1, 0, 5'd8, 1, 0,   0, 0, 0, 2'b10, 2'b10};

    // ---- reset with a load-use hazard presented: controls must stay low
    reset_n = 1'b0;
    drive(1, 5'd4, 5'd0, 0, 5'd4, 1, 1, 5'd0, 0, 0);
    #1;
    check("rst stall_if", stall_if, 0);
    check("rst bubble_ex", bubble_ex, 0);
    check("rst stall_if lat1", stall_if_1, 0);
    tick();
    tick();
    check("rst fwd_a", fwd_a, 2'b00);
    check("rst fwd_b", fwd_b, 2'b00);
    check("rst state", dbg_state, 32'(RUN));
    check("rst cnt", dbg_cnt, 0);
    check_stats("rst", 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    reset_n = 1'b1;
    tick();

    // ---- single-cycle vector table (each from RUN)
    for (int i = 0; i < 12; i++) begin
      drive(vec[i].valid, vec[i].rs1, vec[i].rs2, vec[i].use_rs2, vec[i].ex_rd,
            vec[i].ex_w, vec[i].ex_load, vec[i].mem_rd, vec[i].mem_w, vec[i].br);
      #1;
      check($sformatf("vec%0d stall_if", i), stall_if, vec[i].e_stall);
      check($sformatf("vec%0d stall_id", i), stall_id, vec[i].e_stall);
      check($sformatf("vec%0d bubble_ex", i), bubble_ex, vec[i].e_bubble);
      check($sformatf("vec%0d flush_id", i), flush_id, vec[i].e_flush);
      check($sformatf("vec%0d stall_if lat1", i), stall_if_1, vec[i].e_stall);
      tick();
      check($sformatf("vec%0d fwd_a", i), fwd_a, vec[i].e_fa);
      check($sformatf("vec%0d fwd_b", i), fwd_b, vec[i].e_fb);
      check($sformatf("vec%0d fwd_a lat1", i), fwd_a_1, vec[i].e_fa);
    end

    // ---- load-use, LOAD_LAT=3: exactly three stall cycles
    drive(1, 5'd4, 5'd0, 0, 5'd4, 1, 1, 5'd0, 0, 0);
    #1;
    check("lu c0 stall_if", stall_if, 1);
    check("lu c0 bubble_ex", bubble_ex, 1);
    check("lu c0 stall_if lat1", stall_if_1, 1);
    tick();
    check("lu c0 fwd_a", fwd_a, 2'b00);
    check("lu c0 state", dbg_state, 32'(STALL));
    check("lu c0 cnt", dbg_cnt, 2);
    check("lu c0 state lat1", dbg_state_1, 32'(RUN));
    // bubble now in EX, the load has moved to MEM
    drive(1, 5'd4, 5'd0, 0, 5'd0, 0, 0, 5'd4, 1, 0);
    #1;
    check("lu c1 stall_if", stall_if, 1);
    check("lu c1 bubble_ex", bubble_ex, 1);
    check("lu c1 stall_if lat1", stall_if_1, 0);
    tick();
    check("lu c1 fwd_a", fwd_a, 2'b00);
    check("lu c1 fwd_a lat1", fwd_a_1, 2'b01);
    check("lu c1 cnt", dbg_cnt, 1);
    #1;
    check("lu c2 stall_if", stall_if, 1);
    check("lu c2 bubble_ex", bubble_ex, 1);
    tick();
    check("lu c2 fwd_a", fwd_a, 2'b00);
    check("lu c3 state", dbg_state, 32'(RUN));
    #1;
    check("lu c3 stall_if", stall_if, 0);
    check("lu c3 bubble_ex", bubble_ex, 0);
    tick();
    check("lu c3 fwd_a", fwd_a, 2'b01);
    check_stats("lu", 3, 2);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();

    // ---- branch in the second stall cycle cancels the stall
    drive(1, 5'd4, 5'd0, 0, 5'd4, 1, 1, 5'd0, 0, 0);
    #1;
    check("br c0 stall_if", stall_if, 1);
    tick();
    drive(1, 5'd4, 5'd0, 0, 5'd0, 0, 0, 5'd4, 1, 1);
    #1;
    check("br c1 flush_id", flush_id, 1);
    check("br c1 bubble_ex", bubble_ex, 1);
    check("br c1 stall_if", stall_if, 0);
    check("br c1 stall_id", stall_id, 0);
    tick();
    check("br c1 fwd_a", fwd_a, 2'b00);
    check("br c2 state", dbg_state, 32'(RUN));
    check("br c2 cnt", dbg_cnt, 0);
    drive(1, 5'd1, 5'd2, 1, 5'd0, 0, 0, 5'd0, 0, 0);
    #1;
    check("br c2 stall_if", stall_if, 0);
    check("br c2 flush_id", flush_id, 0);
    tick();
    check_stats("br", 4, 3);

    // ---- reset mid-stall aborts the stall and clears the selects
    drive(1, 5'd4, 5'd0, 0, 5'd4, 1, 1, 5'd0, 0, 0);
    #1;
    check("rms c0 stall_if", stall_if, 1);
    tick();
    check("rms c0 state", dbg_state, 32'(STALL));
    reset_n = 1'b0;
    drive(1, 5'd5, 5'd0, 0, 5'd5, 1, 0, 5'd0, 0, 0);
    #1;
    check("rms stall_if", stall_if, 0);
    check("rms stall_id", stall_id, 0);
    check("rms bubble_ex", bubble_ex, 0);
    check("rms flush_id", flush_id, 0);
    tick();
    check("rms fwd_a", fwd_a, 2'b00);
    check("rms fwd_b", fwd_b, 2'b00);
    check("rms state", dbg_state, 32'(RUN));
    check("rms cnt", dbg_cnt, 0);
    check_stats("rms", 0, 0);
    reset_n = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    check("rms post stall_if", stall_if, 0);
    check("rms post bubble_ex", bubble_ex, 0);
    tick();

    // ---- final report
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
